// File: rtl/mips_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mc_pkg
//  Description : Shared types and constants for the multi-cycle MIPS main
//                control FSM: state encoding, opcodes, ALUOp codes, datapath
//                select codes and the control-word struct.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mc_pkg;

  // Controller states; the three spare 4-bit codes are treated as unreachable
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes understood by the ALU function decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full control word; pc_write and branch are combined into pc_en at the top
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  // True when the opcode is one the controller knows how to sequence
  function automatic logic op_is_legal(input logic [5:0] op, input logic addi_en);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      OP_ADDI:                              legal = addi_en;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage : mips_mc_pkg
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_output_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_output_decode
//  Description : Purely combinational state -> control-word decoder for the
//                multi-cycle MIPS controller. Only the documented handshake
//                gates (mem_ready in FETCH/MEMWRITE) and the illegal-opcode
//                flag in DECODE look at anything besides the state.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_output_decode
  import mips_mc_pkg::*;
#(
  parameter int unsigned ENABLE_ADDI = 1
) (
  input  state_e     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Decode the control word; every field defaults to 0 so unlisted outputs stay low
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        // IR and PC only update once the instruction word has actually arrived
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = ~op_is_legal(op, ENABLE_ADDI != 0);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule : mc_output_decode
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Main control FSM of the multi-cycle MIPS datapath. Holds the
//                state register and next-state logic, waits on the memory
//                ready handshake, and forms pc_en from pc_write/branch/zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int unsigned USE_MEM_READY = 1,
  parameter int unsigned ENABLE_ADDI   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic       instr_done
);

  state_e state_q;
  state_e state_d;
  logic   mem_rdy;
  ctrl_t  ctrl;

  // Zero-wait builds tie the handshake high so every access completes at once
  generate
    if (USE_MEM_READY != 0) begin : g_mem_ready_honour
      assign mem_rdy = mem_ready;
    end else begin : g_mem_ready_ignore
      assign mem_rdy = 1'b1;
    end
  endgenerate

  // Next-state logic; spare encodings recover to FETCH
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = (ENABLE_ADDI != 0) ? S_ADDIEXEC : S_FETCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset drops straight to IDLE even mid-instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  mc_output_decode #(
    .ENABLE_ADDI (ENABLE_ADDI)
  ) u_output_decode (
    .state     (state_q),
    .op        (op),
    .mem_ready (mem_rdy),
    .ctrl      (ctrl)
  );

  assign iord       = ctrl.iord;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign illegal_op = ctrl.illegal_op;
  assign instr_done = ctrl.instr_done;

  // branch is only ever set in BRANCH, so zero matters only there
  assign pc_en = ctrl.pc_write | (ctrl.branch & zero);

endmodule : mips_multicycle_ctrl
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_multicycle_ctrl
//  Description : Self-checking bench for mips_multicycle_ctrl. A per-instruction
//                reference model expands each instruction (with random memory
//                wait counts) into the expected cycle-by-cycle control trace.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;
    logic       instr_done;
  } ctl_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       mr;
    logic       z;
    ctl_t       exp;
  } cyc_t;

  localparam logic [5:0] C_LW   = 6'b100011;
  localparam logic [5:0] C_SW   = 6'b101011;
  localparam logic [5:0] C_RT   = 6'b000000;
  localparam logic [5:0] C_BEQ  = 6'b000100;
  localparam logic [5:0] C_ADDI = 6'b001000;
  localparam logic [5:0] C_J    = 6'b000010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       pc_en, illegal_op, instr_done;
  ctl_t       dut_ctl;

  int errors = 0;
  int checks = 0;
  cyc_t exp_q[$];

  mips_multicycle_ctrl #(
    .USE_MEM_READY (1),
    .ENABLE_ADDI   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .instr_done (instr_done)
  );

  assign dut_ctl = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                    alu_src_b, alu_op, pc_src, pc_en, illegal_op, instr_done};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic rbit();
    logic [31:0] r;
    r = $urandom();
    return r[0];
  endfunction

  function automatic logic [5:0] rop();
    logic [31:0] r;
    r = $urandom();
    return r[5:0];
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return (o == C_LW) || (o == C_SW) || (o == C_RT) || (o == C_BEQ) ||
           (o == C_ADDI) || (o == C_J);
  endfunction

  task automatic push(input string nm, input logic [5:0] o, input logic mr,
                      input logic z, input ctl_t c);
    cyc_t e;
    e.name = nm; e.op = o; e.mr = mr; e.z = z; e.exp = c;
    exp_q.push_back(e);
  endtask

  // Reference model: expand one instruction into its expected per-cycle trace.
  // fw/mw are the number of not-ready cycles in fetch and in the data access.
  task automatic build_instr(input logic [5:0] o, input int fw, input int mw, input logic bz);
    ctl_t c;
    for (int i = 0; i < fw; i++) begin
      c = '0; c.alu_src_b = 2'b01;
      push("fetch_wait", rop(), 1'b0, rbit(), c);
    end
    c = '0; c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_en = 1'b1;
    push("fetch", rop(), 1'b1, rbit(), c);
    c = '0; c.alu_src_b = 2'b11; c.illegal_op = !is_legal(o);
    push("decode", o, rbit(), rbit(), c);
    if (o == C_LW || o == C_SW) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
      push("memadr", o, rbit(), rbit(), c);
      c = '0; c.iord = 1'b1; c.mem_write = (o == C_SW);
      for (int i = 0; i < mw; i++) push("mem_wait", o, 1'b0, rbit(), c);
      c.instr_done = (o == C_SW);
      push("mem_done", o, 1'b1, rbit(), c);
      if (o == C_LW) begin
        c = '0; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
        push("memwb", o, rbit(), rbit(), c);
      end
    end else if (o == C_RT) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b10;
      push("execute", o, rbit(), rbit(), c);
      c = '0; c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
      push("aluwb", o, rbit(), rbit(), c);
    end else if (o == C_BEQ) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01;
      c.instr_done = 1'b1; c.pc_en = bz;
      push("branch", o, rbit(), bz, c);
    end else if (o == C_ADDI) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
      push("addiexec", o, rbit(), rbit(), c);
      c = '0; c.reg_write = 1'b1; c.instr_done = 1'b1;
      push("addiwb", o, rbit(), rbit(), c);
    end else if (o == C_J) begin
      c = '0; c.pc_src = 2'b10; c.pc_en = 1'b1; c.instr_done = 1'b1;
      push("jump", o, rbit(), rbit(), c);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and sample outputs 1ns later
  task automatic run_cycle(input cyc_t e, output ctl_t act);
    @(negedge clk);
    op = e.op; mem_ready = e.mr; zero = e.z;
    #1;
    act = dut_ctl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = rbit(); zero = 1'b1; op = rop();
      #1;
      checks++;
      if (dut_ctl !== '0) begin
        errors++;
        $display("FAIL reset_hold: got %h, expected %h", dut_ctl, 16'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1; zero = 1'b1;
    #1;
    checks++;
    if (dut_ctl !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h, expected %h", dut_ctl, 16'h0);
    end
  endtask

  task automatic test_rtype();
    cyc_t e; ctl_t act; int n; int done_at;
    build_instr(C_RT, 0, 0, rbit());
    n = 0; done_at = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); run_cycle(e, act); n++;
      if (act.instr_done === 1'b1 && done_at == 0) done_at = n;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL rtype %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
    checks++;
    if (done_at != 4) begin
      errors++;
      $display("FAIL rtype_latency: got %0d, expected 4", done_at);
    end
  endtask

  task automatic test_lw_waits();
    cyc_t e; ctl_t act; int n; int done_at; int irw;
    build_instr(C_LW, 2, 3, rbit());
    n = 0; done_at = 0; irw = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); run_cycle(e, act); n++;
      if (act.instr_done === 1'b1 && done_at == 0) done_at = n;
      if (act.ir_write === 1'b1) irw++;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL lw %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
    checks++;
    if (done_at != 10 || irw != 1) begin
      errors++;
      $display("FAIL lw_latency: got done=%0d ir_writes=%0d, expected done=10 ir_writes=1",
               done_at, irw);
    end
  endtask

  task automatic test_beq(input logic z);
    cyc_t e; ctl_t act; int n; int done_at;
    build_instr(C_BEQ, 0, 0, z);
    n = 0; done_at = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); run_cycle(e, act); n++;
      if (act.instr_done === 1'b1 && done_at == 0) begin
        done_at = n;
        checks++;
        if (act.pc_en !== z) begin
          errors++;
          $display("FAIL beq_pc_en: got %b, expected %b", act.pc_en, z);
        end
      end
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL beq %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
    checks++;
    if (done_at != 3) begin
      errors++;
      $display("FAIL beq_latency: got %0d, expected 3", done_at);
    end
  endtask

  task automatic test_sw_then_j();
    cyc_t e; ctl_t act; int mw_cnt; int jmp_ok;
    build_instr(C_SW, 0, 2, rbit());
    build_instr(C_J, 0, 0, rbit());
    mw_cnt = 0; jmp_ok = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); run_cycle(e, act);
      if (act.mem_write === 1'b1) mw_cnt++;
      if (e.name == "jump" && act.pc_src === 2'b10 && act.pc_en === 1'b1) jmp_ok = 1;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL sw_j %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
    checks++;
    if (mw_cnt != 3 || jmp_ok != 1) begin
      errors++;
      $display("FAIL sw_j_summary: got mem_write_cycles=%0d jump_ok=%0d, expected 3 and 1",
               mw_cnt, jmp_ok);
    end
  endtask

  task automatic test_illegal();
    cyc_t e; ctl_t act; int ill;
    build_instr(6'b111111, 0, 0, rbit());
    build_instr(C_ADDI, 0, 0, rbit());
    ill = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); run_cycle(e, act);
      if (act.illegal_op === 1'b1) ill++;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL illegal %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
    checks++;
    if (ill != 1) begin
      errors++;
      $display("FAIL illegal_pulse: got %0d cycles, expected 1", ill);
    end
  endtask

  task automatic test_back_to_back();
    cyc_t e; ctl_t act; logic [5:0] o; logic [31:0] r;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 6);
      case (r)
        0: o = C_LW;
        1: o = C_SW;
        2: o = C_RT;
        3: o = C_BEQ;
        4: o = C_ADDI;
        5: o = C_J;
        default: begin
          o = rop();
          while (is_legal(o)) o = rop();
        end
      endcase
      build_instr(o, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rbit());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); run_cycle(e, act);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL random op=%b %s: got %h, expected %h", e.op, e.name, act, e.exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc_t e; ctl_t act;
    build_instr(C_LW, 0, 4, rbit());
    // fetch, decode, memadr, then two cycles stalled in the read
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front(); run_cycle(e, act);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL reset_mid_pre %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_ctl !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h, expected %h", dut_ctl, 16'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_ctl !== '0) begin
      errors++;
      $display("FAIL reset_mid_hold: got %h, expected %h", dut_ctl, 16'h0);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (dut_ctl !== '0) begin
      errors++;
      $display("FAIL reset_mid_idle: got %h, expected %h", dut_ctl, 16'h0);
    end
    build_instr(C_RT, 0, 0, rbit());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); run_cycle(e, act);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL reset_mid_restart %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_waits();
    test_beq(1'b1);
    test_beq(1'b0);
    test_sw_then_j();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mips_multicycle_ctrl
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath. It sequences one shared ALU, one unified memory and the register file across several cycles per instruction.
- Drives the 2-bit ALU-operation code consumed by the existing ALU function decoder, plus all datapath mux selects and write enables.
- Waits on a memory ready handshake during fetch, load and store.

Parameters:
- USE_MEM_READY, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1 (zero-wait memory).
- ENABLE_ADDI, 1, 1 = decode addi; 0 = addi is treated as an illegal opcode.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op  input  6  opcode field from the instruction register (stable after FETCH).
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completed the current access this cycle.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write-back data select: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- alu_op  output  2  00 = add, 01 = sub, 10 = use funct.
- pc_src  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pc_en  output  1  PC load enable.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- instr_done  output  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- State encoding: Moore FSM with a registered state.
  - All outputs are decoded from the state only.
  - Exceptions: pc_en, plus any output documented as gated by mem_ready or zero.
- Reset behaviour: rst_n low forces IDLE immediately, mid-instruction included. Every output is 0 in IDLE.
- Unlisted outputs are 0 in every state.
- IDLE -> FETCH unconditionally, one cycle after rst_n is released.
- FETCH:
  - Outputs: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write are asserted only when mem_ready=1; the state then moves to DECODE. Otherwise the FSM holds in FETCH.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - op 100011 (lw) or 101011 (sw) -> MEMADR.
  - op 000000 (R-type) -> EXECUTE.
  - op 000100 (beq) -> BRANCH.
  - op 001000 (addi, if ENABLE_ADDI) -> ADDIEXEC.
  - op 000010 (j) -> JUMP.
  - Any other op: illegal_op=1 for this cycle, next state FETCH, no architectural write.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - lw -> MEMREAD, else -> MEMWRITE.
- MEMREAD: iord=1; holds until mem_ready, then -> MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH.
- MEMWRITE:
  - iord=1 and mem_write=1, both held until mem_ready.
  - In the mem_ready cycle: instr_done=1 -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1 -> FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 -> FETCH.
- pc_en = pc_write | (branch & zero). This is combinational; zero is sampled in BRANCH only.
- Latency with zero-wait memory, in cycles:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
  - Each mem_ready=0 cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- Unreachable state encodings -> FETCH on the next edge.

Decomposition:
- Package mips_mc_pkg:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - alu_src_b and pc_src select constants.
- Natural sub-module: mc_output_decode, a purely combinational state -> control-word decoder. The top level keeps the state register, next-state logic and pc_en.

Test Plan:
- Reset and idle: hold rst_n=0, then release. Required: all outputs 0 in IDLE. The first FETCH follows one cycle after release, with alu_src_b=01 and pc_en=1 (mem_ready=1).
- R-type: op=000000, zero-wait memory. Required: state sequence FETCH, DECODE, EXECUTE, ALUWB. EXECUTE has alu_op=10. ALUWB has reg_dst=1, reg_write=1, instr_done=1. Total 4 cycles.
- lw with waits: op=100011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD. Required: 10 cycles total. ir_write appears only in the mem_ready cycle. MEMWB has mem_to_reg=1 and reg_write=1.
- beq:
  - op=000100 with zero=1 -> BRANCH has alu_op=01, pc_src=01, pc_en=1.
  - Repeat with zero=0 -> pc_en=0.
  - Both cases take 3 cycles.
- sw then j: for sw, mem_write stays high through 2 wait cycles and drops after mem_ready. For j, pc_src=10 and pc_en=1 in JUMP.
- Illegal opcode and reset mid-instruction:
  - op=111111 -> illegal_op is 1 for exactly 1 cycle in DECODE, with no reg_write or mem_write.
  - rst_n=0 while in MEMREAD -> outputs go to 0 asynchronously, and the FSM restarts at IDLE.
